eth_rx: RTL and testbench

RMII receive datapath, the counterpart of the transmit path. Runs on the 50 MHz RMII reference clock and samples one dibit per cycle (100 Mb/s). Hunts for preamble/SFD and assembles bytes LSB-first. Captures the destination, source and length/type fields. Streams payload bytes with the 4 FCS bytes stripped, then flags end-of-frame with a pass/fail status.

---
 rtl/eth_rx_pkg.sv | 39 +++
 rtl/eth_crc32_d2.sv | 34 +++
 rtl/eth_rx.sv | 238 +++++++++++++++++++++++
 tb/tb_eth_rx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the RMII receive path and its 2-bit CRC-32 helper.
package eth_rx_pkg;

  localparam int pMII_WIDTH = 2;

  localparam logic [1:0] PRE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT = 2'b11;

  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  // Byte-counter values of the last byte of each header field.
  localparam logic [10:0] DEST_LAST = 11'd5;
  localparam logic [10:0] SRC_LAST  = 11'd11;
  localparam logic [10:0] LEN_LAST  = 11'd13;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DEST_ADDR,
    SRC_ADDR,
    LEN_TYPE,
    DATA,
    DROP
  } rx_state_t;

  // Reflected CRC-32 advanced by one RMII dibit, bit[0] first.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc,
                                             input logic [pMII_WIDTH-1:0] din);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < pMII_WIDTH; i++) begin
      c = (c >> 1) ^ ((c[0] ^ din[i]) ? CRC_POLY : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32_d2.sv
// CRC-32 (reflected 0xEDB88320) consuming one dibit per cycle; Init wins over En.
module eth_crc32_d2
  import eth_rx_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Init,
  input  logic        En,
  input  logic [1:0]  Din,
  output logic [31:0] Crc
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (Init) begin
      crc_d = CRC_INIT;
    end else if (En) begin
      crc_d = crc32_step(crc_q, Din);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign Crc = crc_q;

endmodule

// File: rtl/eth_rx.sv
// RMII receive datapath: preamble/SFD hunt, header capture, payload streaming with FCS strip.
// Define ETH_RX_CRC_CHK_EN to fold a CRC-32 residue check into the end-of-frame status.
module eth_rx
  import eth_rx_pkg::*;
#(
  parameter int pMIN_PRE_DIBITS = 8,
  parameter int pMIN_FRAME      = 64,
  parameter int pMAX_FRAME      = 1518
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [1:0]  Rx_Data,
  input  logic        Crs_Dv,
  output logic [47:0] Dest_Addr,
  output logic [47:0] Src_Addr,
  output logic [15:0] Len_Type,
  output logic        Hdr_Vld,
  output logic [7:0]  Rx_Byte,
  output logic        Rx_Byte_Vld,
  output logic        Rx_Sof,
  output logic        Rx_Eof,
  output logic        Rx_Err
);

  rx_state_t       state_q, state_d;
  logic            armed_q, armed_d;
  logic [7:0]      pre_cnt_q, pre_cnt_d;
  logic [1:0]      phase_q, phase_d;
  logic [10:0]     byte_cnt_q, byte_cnt_d;
  logic [2:0]      dl_cnt_q, dl_cnt_d;
  logic            sof_pend_q, sof_pend_d;

  logic [7:0]      shift_q, shift_d;
  logic [3:0][7:0] dl_q, dl_d;
  logic [47:0]     dest_sh_q, dest_sh_d;
  logic [47:0]     src_sh_q, src_sh_d;
  logic [7:0]      len_sh_q, len_sh_d;

  logic [47:0]     dest_q, dest_d;
  logic [47:0]     src_q, src_d;
  logic [15:0]     len_q, len_d;
  logic            hdr_vld_q, hdr_vld_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            rx_byte_vld_q, rx_byte_vld_d;
  logic            rx_sof_q, rx_sof_d;
  logic            rx_eof_q, rx_eof_d;
  logic            rx_err_q, rx_err_d;

  logic            in_frame;
  logic            sfd_hit;
  logic            crc_bad;
  logic [7:0]      byte_new;

  assign in_frame = state_q inside {DEST_ADDR, SRC_ADDR, LEN_TYPE, DATA};
  assign sfd_hit  = (state_q == PREAMBLE) && Crs_Dv && (Rx_Data == SFD_DIBIT) &&
                    (int'(pre_cnt_q) >= pMIN_PRE_DIBITS);
  assign byte_new = {Rx_Data, shift_q[7:2]};

`ifdef ETH_RX_CRC_CHK_EN
  logic [31:0] crc;

  eth_crc32_d2 u_crc (
    .Clk  (Clk),
    .Rst  (Rst),
    .Init (sfd_hit),
    .En   (in_frame & Crs_Dv),
    .Din  (Rx_Data),
    .Crc  (crc)
  );

  assign crc_bad = (crc != CRC_RESIDUE);
`else
  assign crc_bad = 1'b0;
`endif

  always_comb begin
    // NOTE: every _d gets a default before any branch, so no path leaves a latch behind.
    state_d       = state_q;
    armed_d       = armed_q | ~Crs_Dv;
    pre_cnt_d     = pre_cnt_q;
    phase_d       = phase_q;
    byte_cnt_d    = byte_cnt_q;
    dl_cnt_d      = dl_cnt_q;
    sof_pend_d    = sof_pend_q;
    shift_d       = shift_q;
    dl_d          = dl_q;
    dest_sh_d     = dest_sh_q;
    src_sh_d      = src_sh_q;
    len_sh_d      = len_sh_q;
    dest_d        = dest_q;
    src_d         = src_q;
    len_d         = len_q;
    rx_byte_d     = rx_byte_q;
    hdr_vld_d     = 1'b0;
    rx_byte_vld_d = 1'b0;
    rx_sof_d      = 1'b0;
    rx_eof_d      = 1'b0;
    rx_err_d      = 1'b0;

    if (in_frame && Crs_Dv) begin
      shift_d = byte_new;
      phase_d = phase_q + 2'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (armed_q && Crs_Dv && (Rx_Data == PRE_DIBIT)) begin
          state_d   = PREAMBLE;
          pre_cnt_d = 8'd1;
        end
      end

      PREAMBLE: begin
        if (!Crs_Dv) begin
          state_d = IDLE;
        end else if (Rx_Data == PRE_DIBIT) begin
          if (pre_cnt_q != 8'hFF) pre_cnt_d = pre_cnt_q + 8'd1;
        end else if (sfd_hit) begin
          state_d    = DEST_ADDR;
          byte_cnt_d = '0;
          phase_d    = '0;
          dl_cnt_d   = '0;
          sof_pend_d = 1'b1;
        end else begin
          state_d = DROP;
        end
      end

      DROP: begin
        if (!Crs_Dv) state_d = IDLE;
      end

      default: begin
        if (!Crs_Dv) begin
          // A dibit missing from a byte in progress leaves phase_q nonzero.
          state_d  = IDLE;
          rx_eof_d = 1'b1;
          rx_err_d = (int'(byte_cnt_q) < pMIN_FRAME) || (int'(byte_cnt_q) > pMAX_FRAME) ||
                     (phase_q != 2'd0) || (state_q != DATA) || crc_bad;
        end else if (phase_q == 2'd3) begin
          if (byte_cnt_q != 11'h7FF) byte_cnt_d = byte_cnt_q + 11'd1;
          case (state_q)
            DEST_ADDR: begin
              dest_sh_d = {dest_sh_q[39:0], byte_new};
              if (byte_cnt_q == DEST_LAST) state_d = SRC_ADDR;
            end
            SRC_ADDR: begin
              src_sh_d = {src_sh_q[39:0], byte_new};
              if (byte_cnt_q == SRC_LAST) state_d = LEN_TYPE;
            end
            LEN_TYPE: begin
              len_sh_d = byte_new;
              if (byte_cnt_q == LEN_LAST) begin
                state_d   = DATA;
                hdr_vld_d = 1'b1;
                dest_d    = dest_sh_q;
                src_d     = src_sh_q;
                len_d     = {len_sh_q, byte_new};
              end
            end
            default: begin
              // Four-byte delay line: whatever is still inside at Crs_Dv low is the FCS.
              dl_d = {dl_q[2:0], byte_new};
              if (dl_cnt_q == 3'd4) begin
                rx_byte_d     = dl_q[3];
                rx_byte_vld_d = 1'b1;
                rx_sof_d      = sof_pend_q;
                sof_pend_d    = 1'b0;
              end else begin
                dl_cnt_d = dl_cnt_q + 3'd1;
              end
            end
          endcase
        end
      end
    endcase
  end

  // NOTE: registers take <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= IDLE;
      armed_q       <= 1'b0;
      pre_cnt_q     <= '0;
      phase_q       <= '0;
      byte_cnt_q    <= '0;
      dl_cnt_q      <= '0;
      sof_pend_q    <= 1'b0;
      dest_q        <= '0;
      src_q         <= '0;
      len_q         <= '0;
      hdr_vld_q     <= 1'b0;
      rx_byte_q     <= '0;
      rx_byte_vld_q <= 1'b0;
      rx_sof_q      <= 1'b0;
      rx_eof_q      <= 1'b0;
      rx_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      armed_q       <= armed_d;
      pre_cnt_q     <= pre_cnt_d;
      phase_q       <= phase_d;
      byte_cnt_q    <= byte_cnt_d;
      dl_cnt_q      <= dl_cnt_d;
      sof_pend_q    <= sof_pend_d;
      dest_q        <= dest_d;
      src_q         <= src_d;
      len_q         <= len_d;
      hdr_vld_q     <= hdr_vld_d;
      rx_byte_q     <= rx_byte_d;
      rx_byte_vld_q <= rx_byte_vld_d;
      rx_sof_q      <= rx_sof_d;
      rx_eof_q      <= rx_eof_d;
      rx_err_q      <= rx_err_d;
    end
  end

  // NOTE: shift, delay-line and header shadow contents are only read once the counters and
  // state qualify them, so they skip reset and stay plain data flops.
  always_ff @(posedge Clk) begin
    shift_q   <= shift_d;
    dl_q      <= dl_d;
    dest_sh_q <= dest_sh_d;
    src_sh_q  <= src_sh_d;
    len_sh_q  <= len_sh_d;
  end

  assign Dest_Addr   = dest_q;
  assign Src_Addr    = src_q;
  assign Len_Type    = len_q;
  assign Hdr_Vld     = hdr_vld_q;
  assign Rx_Byte     = rx_byte_q;
  assign Rx_Byte_Vld = rx_byte_vld_q;
  assign Rx_Sof      = rx_sof_q;
  assign Rx_Eof      = rx_eof_q;
  assign Rx_Err      = rx_err_q;

endmodule

// File: tb/tb_eth_rx.sv
// Frame-level bench for eth_rx: expected header, payload and status come from the byte image.
module tb_eth_rx;

  localparam int MIN_FRAME = 64;
  localparam int MAX_FRAME = 1518;
`ifdef ETH_RX_CRC_CHK_EN
  localparam bit CRC_CHK = 1'b1;
`else
  localparam bit CRC_CHK = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [1:0]  Rx_Data = 2'b00;
  logic        Crs_Dv = 1'b0;
  logic [47:0] Dest_Addr;
  logic [47:0] Src_Addr;
  logic [15:0] Len_Type;
  logic        Hdr_Vld;
  logic [7:0]  Rx_Byte;
  logic        Rx_Byte_Vld;
  logic        Rx_Sof;
  logic        Rx_Eof;
  logic        Rx_Err;

  eth_rx #(
    .pMIN_PRE_DIBITS (8),
    .pMIN_FRAME      (MIN_FRAME),
    .pMAX_FRAME      (MAX_FRAME)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Rx_Data     (Rx_Data),
    .Crs_Dv      (Crs_Dv),
    .Dest_Addr   (Dest_Addr),
    .Src_Addr    (Src_Addr),
    .Len_Type    (Len_Type),
    .Hdr_Vld     (Hdr_Vld),
    .Rx_Byte     (Rx_Byte),
    .Rx_Byte_Vld (Rx_Byte_Vld),
    .Rx_Sof      (Rx_Sof),
    .Rx_Eof      (Rx_Eof),
    .Rx_Err      (Rx_Err)
  );

  always #10 Clk = ~Clk;

  int           total = 0;
  int           bad = 0;
  int           n_seen = 0;
  int           n0 = 0;
  logic [7:0]   first_byte = 8'h00;
  logic [7:0]   last_byte = 8'h00;
  logic [7:0]   frame[$];
  logic [111:0] exp_hdr[$];
  logic [8:0]   exp_byte[$];
  logic         exp_eof[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Standard Ethernet FCS over frame[0..len-1] (reflected, complemented at the end).
  function automatic logic [31:0] fcs_of(input int len);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < len; i++) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ frame[i][b]) c = (c >> 1) ^ 32'hEDB8_8320;
        else                    c = c >> 1;
      end
    end
    return ~c;
  endfunction

  task automatic build_frame(input int n_total);
    logic [31:0] f;
    frame.delete();
    repeat (6) frame.push_back(8'hFF);
    frame.push_back(8'h02);
    repeat (4) frame.push_back(8'h00);
    frame.push_back(8'h01);
    frame.push_back(8'h08);
    frame.push_back(8'h00);
    for (int i = 0; i < n_total - 18; i++) frame.push_back(8'(i));
    f = fcs_of(frame.size());
    for (int i = 0; i < 4; i++) frame.push_back(8'(f >> (8 * i)));
  endtask

  // Status of a frame whose first n_full bytes plus `extra` dibits arrived.
  function automatic logic model_err(input int n_full, input int extra);
    int          n;
    logic        crc_ok;
    logic [31:0] wire_fcs;
    n = frame.size();
    wire_fcs = {frame[n-1], frame[n-2], frame[n-3], frame[n-4]};
    crc_ok = (n_full == n) && (extra == 0) && (fcs_of(n - 4) == wire_fcs);
    return (n_full < MIN_FRAME) || (n_full > MAX_FRAME) || (extra != 0) ||
           (n_full < 14) || (CRC_CHK && !crc_ok);
  endfunction

  // Expectations for a frame whose first `done` bytes completed; payload excludes the last 4.
  task automatic expect_frame(input int done, input int extra, input bit with_eof);
    if (done >= 14)
      exp_hdr.push_back({frame[0], frame[1], frame[2], frame[3], frame[4], frame[5],
                         frame[6], frame[7], frame[8], frame[9], frame[10], frame[11],
                         frame[12], frame[13]});
    for (int i = 14; i <= done - 5; i++) exp_byte.push_back({i == 14, frame[i]});
    if (with_eof) exp_eof.push_back(model_err(done, extra));
  endtask

  task automatic compare_cycle();
    logic [111:0] h;
    logic [8:0]   eb;
    logic         ee;
    if (Hdr_Vld === 1'b1) begin
      if (exp_hdr.size() == 0) check("unexpected Hdr_Vld", Hdr_Vld, 0);
      else begin
        h = exp_hdr.pop_front();
        check("header fields", {Dest_Addr, Src_Addr, Len_Type}, h);
      end
    end
    if (Rx_Byte_Vld === 1'b1) begin
      n_seen++;
      last_byte = Rx_Byte;
      if (Rx_Sof === 1'b1) first_byte = Rx_Byte;
      if (exp_byte.size() == 0) check("unexpected Rx_Byte_Vld", Rx_Byte_Vld, 0);
      else begin
        eb = exp_byte.pop_front();
        check("payload sof+byte", {Rx_Sof, Rx_Byte}, eb);
      end
    end else if (Rx_Sof === 1'b1) begin
      check("Rx_Sof without strobe", Rx_Sof, 0);
    end
    if (Rx_Eof === 1'b1) begin
      if (exp_eof.size() == 0) check("unexpected Rx_Eof", Rx_Eof, 0);
      else begin
        ee = exp_eof.pop_front();
        check("eof status", Rx_Err, ee);
      end
    end
  endtask

  task automatic drive(input logic [1:0] d);
    @(negedge Clk);
    Crs_Dv  = 1'b1;
    Rx_Data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clk);
      Crs_Dv  = 1'b0;
      Rx_Data = 2'b00;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " header outputs"}, {Dest_Addr, Src_Addr, Len_Type}, 0);
    check({tag, " strobes/byte"}, {Hdr_Vld, Rx_Byte_Vld, Rx_Sof, Rx_Eof, Rx_Err, Rx_Byte}, 0);
  endtask

  // Preamble, SFD, then n_bytes whole bytes plus `extra` dibits; Rst pulses 3 cycles at rst_at.
  task automatic send(input int n_pre, input int n_bytes, input int extra, input int rst_at);
    logic [7:0] t;
    for (int i = 0; i < n_pre; i++) drive(2'b01);
    drive(2'b11);
    for (int j = 0; j < n_bytes * 4 + extra; j++) begin
      t = frame[j / 4] >> (2 * (j % 4));
      drive(t[1:0]);
      if (j == rst_at) Rst = 1'b1;
      if (rst_at >= 0 && j == rst_at + 3) begin
        check_all_zero("after mid-frame reset");
        Rst = 1'b0;
      end
    end
  endtask

  task automatic drain(input string tag);
    check({tag, " headers left"}, exp_hdr.size(), 0);
    check({tag, " bytes left"}, exp_byte.size(), 0);
    check({tag, " eofs left"}, exp_eof.size(), 0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge Clk);
        compare_cycle();
      end
    join_none

    repeat (3) @(negedge Clk);
    check_all_zero("reset");
    Rst = 1'b0;
    idle(5);

    // Good 64-byte frame.
    build_frame(64);
    n0 = n_seen;
    expect_frame(64, 0, 1'b1);
    send(31, 64, 0, -1);
    idle(12);
    drain("good64");
    check("good64 byte count", n_seen - n0, 46);
    check("good64 first byte", first_byte, 8'h00);
    check("good64 last byte", last_byte, 8'h2D);
    check("good64 Dest_Addr", Dest_Addr, 48'hFFFF_FFFF_FFFF);
    check("good64 Src_Addr", Src_Addr, 48'h0200_0000_0001);
    check("good64 Len_Type", Len_Type, 16'h0800);

    // Same frame, one payload bit flipped after the FCS was computed.
    build_frame(64);
    frame[30] = frame[30] ^ 8'h08;
    n0 = n_seen;
    expect_frame(64, 0, 1'b1);
    send(31, 64, 0, -1);
    idle(12);
    drain("bitflip");
    check("bitflip byte count", n_seen - n0, 46);

    // Short preamble: dropped silently, header outputs keep their previous value.
    build_frame(64);
    n0 = n_seen;
    send(4, 64, 0, -1);
    idle(12);
    drain("short preamble");
    check("short preamble byte count", n_seen - n0, 0);
    check("short preamble header held", Len_Type, 16'h0800);

    // Truncated after 20 bytes plus one dibit.
    n0 = n_seen;
    expect_frame(20, 1, 1'b1);
    send(31, 20, 1, -1);
    idle(12);
    drain("truncated");
    check("truncated byte count", n_seen - n0, 2);

    // Reset mid-payload after 30 bytes + 2 dibits, carrier kept high to the end of the frame.
    n0 = n_seen;
    expect_frame(30, 0, 1'b0);
    send(31, 64, 0, 122);
    idle(12);
    drain("mid-frame reset");
    check("mid-frame reset byte count", n_seen - n0, 12);
    check("no relock header", Dest_Addr, 48'h0);

    n0 = n_seen;
    expect_frame(64, 0, 1'b1);
    send(31, 64, 0, -1);
    idle(12);
    drain("post-reset frame");
    check("post-reset byte count", n_seen - n0, 46);

    // Oversize 1519-byte frame with a valid FCS.
    build_frame(1519);
    n0 = n_seen;
    expect_frame(1519, 0, 1'b1);
    send(31, 1519, 0, -1);
    idle(12);
    drain("oversize");
    check("oversize byte count", n_seen - n0, 1501);
    check("oversize last byte", last_byte, 8'hDC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
